logic_pipe_stage: RTL and testbench

//   Registered bitwise logic stage that consumes the two-input gate primitives (and/or/xor/nor)
//   and presents their result to the ALU result bus. Two-stage pipeline: operand capture, then

---
 rtl/logic_pipe_stage.sv | 133 +++++++++++++
 tb/tb_logic_pipe_stage.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage
//   Two-stage registered bitwise logic unit. Stage 1 captures an operand set
//   {op, a, b}. Stage 2 computes AND/OR/XOR/NOR, registers the result with a
//   zero flag and a parity flag, and presents it to the result bus. Both sides
//   use a valid/ready handshake and the pipe sustains one transfer per cycle.
//   A free-running counter tracks completed output transfers.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set on op/a/b is valid
//   in_ready   stage accepts operands this cycle (combinational, low in reset)
//   op         00=AND 01=OR 10=XOR 11=NOR
//   a, b       operands, WIDTH bits
//   out_valid  y/zero/parity are valid
//   out_ready  downstream accepts the result this cycle
//   y          result, WIDTH bits
//   zero       1 when y is all zeros
//   parity     XOR-reduction of y (1 = odd number of ones)
//   xfer_cnt   completed output transfers, wraps modulo 2^CNT_W
module logic_pipe_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             s1_valid_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             parity_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_take;
  logic             s1_take;
  logic [WIDTH-1:0] y_d;
  logic [CNT_W-1:0] cnt_d;

  // Each stage may load when it is empty or when its content leaves this
  // cycle. Chaining s1_take off s2_take lets a full pipe accept a new operand
  // in the same cycle the result is taken, so there is never a bubble.
  always_comb begin
    s2_take  = !out_valid_q || out_ready;
    s1_take  = !s1_valid_q || s2_take;
    in_ready = s1_take && !rst;
  end

  // Gate function applied to the captured operands; the result is exact over
  // WIDTH bits with no carries between bit positions.
  always_comb begin
    y_d = '0;
    unique case (op_q)
      2'b00:   y_d = a_q & b_q;
      2'b01:   y_d = a_q | b_q;
      2'b10:   y_d = a_q ^ b_q;
      default: y_d = ~(a_q | b_q);
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Stage 1: operand capture. The operand registers only load when a real
  // operand arrives, so a bubble leaves the previous values in place; they are
  // ignored because s1_valid_q is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else if (s1_take) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

  // Stage 2: compute and register the result with its flags. When a bubble
  // advances, out_valid drops but the last result stays on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else if (s2_take) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q      <= y_d;
        zero_q   <= (y_d == '0);
        parity_q <= ^y_d;
      end
    end
  end

  // Completed-transfer counter, wraps naturally with no saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_pipe_stage.sv
// tb_logic_pipe_stage
//   Drives logic_pipe_stage (WIDTH=8, CNT_W=16) plus a second copy with
//   CNT_W=4 sharing the same stimulus, and checks both against a
//   transaction-level reference: a queue of accepted results, each tagged with
//   the edge that accepted it.
module tb_logic_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  y;
  logic        zero;
  logic        parity;
  logic [15:0] xfer_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  y4;
  logic        zero4;
  logic        parity4;
  logic [3:0]  xfer_cnt4;

  int errors = 0;
  int checks = 0;

  logic [30:0] obsVec;
  assign obsVec = {out_valid, y, zero, parity, xfer_cnt, xfer_cnt4};

  localparam logic [7:0] TT_Y [4] = '{8'h08, 8'h0E, 8'h06, 8'hF1};
  localparam logic       TT_P [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic_pipe_stage #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .xfer_cnt(xfer_cnt)
  );

  logic_pipe_stage #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .zero(zero4), .parity(parity4), .xfer_cnt(xfer_cnt4)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       p;
    int         acc;
  } item_t;

  item_t       mq[$];
  int          edgeNo = 0;
  logic [7:0]  heldY = 8'h00;
  logic        heldZ = 1'b0;
  logic        heldP = 1'b0;
  logic [15:0] cnt16 = 16'd0;
  logic [3:0]  cnt4 = 4'd0;

  function automatic item_t refItem(input logic [1:0] o, input logic [7:0] x, input logic [7:0] w);
    item_t r;
    case (o)
      2'd0:    r.y = x & w;
      2'd1:    r.y = x | w;
      2'd2:    r.y = x ^ w;
      default: r.y = ~(x | w);
    endcase
    r.z   = (r.y == 8'h00);
    r.p   = ($countones(r.y) % 2) == 1;
    r.acc = 0;
    return r;
  endfunction

  // The oldest result is visible once at least one edge has passed since it
  // was accepted.
  function automatic bit expOV();
    return mq.size() > 0 && edgeNo > mq[0].acc;
  endfunction

  // Two results fit in the pipe; when both are held, a new one only fits if
  // the oldest leaves this cycle.
  function automatic bit expIR();
    return !rst && (mq.size() < 2 || out_ready);
  endfunction

  function automatic logic [30:0] expVec();
    return {expOV(), heldY, heldZ, heldP, cnt16, cnt4};
  endfunction

  // Reference model update at each rising edge, from the bench's own inputs.
  always @(posedge clk) begin : model
    bit    vis;
    bit    acc;
    item_t it;
    vis = expOV();
    acc = in_valid && expIR();
    edgeNo++;
    if (rst) begin
      mq.delete();
      cnt16 = 16'd0;
      cnt4  = 4'd0;
      heldY = 8'h00;
      heldZ = 1'b0;
      heldP = 1'b0;
    end else begin
      if (vis && out_ready) begin
        void'(mq.pop_front());
        cnt16 = cnt16 + 16'd1;
        cnt4  = cnt4 + 4'd1;
      end
      if (acc) begin
        it     = refItem(op, a, b);
        it.acc = edgeNo;
        mq.push_back(it);
      end
      if (expOV()) begin
        heldY = mq[0].y;
        heldZ = mq[0].z;
        heldP = mq[0].p;
      end
    end
  end

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (obsVec !== 31'd0) begin
      errors++; $display("[TB] FAIL reset_state: got %h expected %h", obsVec, 31'd0);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_truth();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'(i); a = 8'h0C; b = 8'h0A;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL truth_in_ready op=%0d: got %b expected 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL truth_latency op=%0d: out_valid got %b expected 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, y, zero, parity} !== {1'b1, TT_Y[i], 1'b0, TT_P[i]}) begin
        errors++;
        $display("[TB] FAIL truth_result op=%0d: got v=%b y=%h z=%b p=%b expected v=1 y=%h z=0 p=%b",
                 i, out_valid, y, zero, parity, TT_Y[i], TT_P[i]);
      end
      checks++;
      if (obsVec !== expVec()) begin
        errors++; $display("[TB] FAIL truth_model op=%0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_zero();
    logic [1:0] zo [2];
    logic [7:0] za [2];
    logic [7:0] zb [2];
    zo[0] = 2'd0; za[0] = 8'hF0; zb[0] = 8'h0F;
    zo[1] = 2'd3; za[1] = 8'hFF; zb[1] = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = zo[i]; a = za[i]; b = zb[i];
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, y, zero, parity} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL zero_flag case=%0d: got v=%b y=%h z=%b p=%b expected v=1 y=00 z=1 p=0",
                 i, out_valid, y, zero, parity);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] vo [3];
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] got[$];
    int k = 0;
    for (int i = 0; i < 3; i++) begin
      vo[i] = 2'($urandom_range(0, 3)); va[i] = 8'($urandom); vb[i] = 8'($urandom);
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec()) begin
        errors++; $display("[TB] FAIL bp_model c=%0d: got %h expected %h", c, obsVec, expVec());
      end
      out_ready = (c >= 6);
      in_valid  = (k < 3);
      if (k < 3) begin
        op = vo[k]; a = va[k]; b = vb[k];
      end
      #1;
      checks++;
      if (in_ready !== expIR()) begin
        errors++; $display("[TB] FAIL bp_in_ready c=%0d: got %b expected %b", c, in_ready, expIR());
      end
      if (c == 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL bp_full_stall: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
        end
      end
      if (c == 6) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL bp_same_cycle_ready: got %b expected 1", in_ready);
        end
      end
      if (in_valid && expIR()) k++;
      if (out_valid === 1'b1 && out_ready) got.push_back(y);
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++; $display("[TB] FAIL bp_count: got %0d results expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        item_t r;
        r = refItem(vo[i], va[i], vb[i]);
        checks++;
        if (got[i] !== r.y) begin
          errors++; $display("[TB] FAIL bp_order idx=%0d: got %h expected %h", i, got[i], r.y);
        end
      end
    end
  endtask

  task automatic test_throughput();
    int firstOV = -1;
    int lastOV  = -1;
    int nOV     = 0;
    pulseReset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obsVec !== expVec()) begin
        errors++; $display("[TB] FAIL tp_model c=%0d: got %h expected %h", c, obsVec, expVec());
      end
      if (out_valid === 1'b1) begin
        if (firstOV < 0) firstOV = c;
        lastOV = c;
        nOV++;
      end
      in_valid = (c < 16);
      op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
    end
    in_valid = 1'b0;
    checks++;
    if (firstOV != 2 || nOV != 16 || lastOV - firstOV + 1 != 16) begin
      errors++; $display("[TB] FAIL tp_stream: got first=%0d count=%0d last=%0d expected 2 16 17", firstOV, nOV, lastOV);
    end
    checks++;
    if (xfer_cnt !== 16'd16) begin
      errors++; $display("[TB] FAIL tp_xfer_cnt: got %0d expected 16", xfer_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'd1; a = 8'h5A; b = 8'hA5;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL mf_filled: out_valid got %b expected 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mf_in_ready_rst: got %b expected 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, y, xfer_cnt} !== {1'b0, 8'h00, 16'd0}) begin
      errors++; $display("[TB] FAIL mf_after_reset: got v=%b y=%h cnt=%0d expected v=0 y=00 cnt=0", out_valid, y, xfer_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || xfer_cnt !== 16'd0) begin
        errors++; $display("[TB] FAIL mf_stale c=%0d: got v=%b cnt=%0d expected v=0 cnt=0", c, out_valid, xfer_cnt);
      end
    end
    in_valid = 1'b1; op = 2'd2; a = 8'h3C; b = 8'h0F;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mf_first_accept: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, y} !== {1'b1, 8'h33}) begin
      errors++; $display("[TB] FAIL mf_first_result: got v=%b y=%h expected v=1 y=33", out_valid, y);
    end
  endtask

  task automatic test_wrap();
    pulseReset();
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obsVec !== expVec()) begin
        errors++; $display("[TB] FAIL wrap_model c=%0d: got %h expected %h", c, obsVec, expVec());
      end
      if (cnt16 == 16'd15) begin
        checks++;
        if (xfer_cnt4 !== 4'd15) begin
          errors++; $display("[TB] FAIL wrap_15: got %0d expected 15", xfer_cnt4);
        end
      end
      if (cnt16 == 16'd16) begin
        checks++;
        if (xfer_cnt4 !== 4'd0) begin
          errors++; $display("[TB] FAIL wrap_0: got %0d expected 0", xfer_cnt4);
        end
      end
      if (cnt16 == 16'd17) begin
        checks++;
        if (xfer_cnt4 !== 4'd1) begin
          errors++; $display("[TB] FAIL wrap_1: got %0d expected 1", xfer_cnt4);
        end
      end
      in_valid = (c < 17);
      op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    pulseReset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expVec()) begin
        errors++; $display("[TB] FAIL rand_model c=%0d: got %h expected %h", c, obsVec, expVec());
      end
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
      #1;
      checks++;
      if (in_ready !== expIR()) begin
        errors++; $display("[TB] FAIL rand_in_ready c=%0d: got %b expected %b", c, in_ready, expIR());
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth();
    test_zero();
    test_backpressure();
    test_throughput();
    test_reset_midflight();
    test_wrap();
    test_random();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
